// File: rtl/booth_pkg.sv
// booth_pkg: shared state, selector type and radix-4 Booth recoding for booth_seq_mult
// No ports; provides state_t, booth_sel_t and booth_encode().
package booth_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef struct packed {
        logic s;
        logic d;
        logic n;
    } booth_sel_t;
    // Triplet {b[2i+1], b[2i], b[2i-1]} -> select A, select 2A, negate
    function automatic booth_sel_t booth_encode(input logic [2:0] t);
        booth_sel_t r;
        r.s = t[1] ^ t[0];
        r.d = (t == 3'b011) || (t == 3'b100);
        r.n = t[2] && !(t[1] && t[0]);
        return r;
    endfunction
endpackage

// File: rtl/booth_seq_mult_if.sv
// booth_seq_mult_if: operand/product handshake bundle for booth_seq_mult
// in_valid/in_ready/a/b (+ is_unsigned with BOOTH_UNSIGNED_EN) toward the multiplier,
// out_valid/out_ready/product back to the consumer; master = producer/consumer, slave = multiplier.
interface booth_seq_mult_if #(parameter int W = 8);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
`ifdef BOOTH_UNSIGNED_EN
    logic           is_unsigned;
    modport master (output in_valid, a, b, is_unsigned, out_ready, input in_ready, out_valid, product);
    modport slave  (input in_valid, a, b, is_unsigned, out_ready, output in_ready, out_valid, product);
`else
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, product);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, product);
`endif
endinterface

// File: rtl/booth_pp_row.sv
// booth_pp_row: one radix-4 Booth partial-product selector row, W+2 bits wide
// a_i: extended multiplicand, sel_i: {s,d,n}; pp_o: selected (possibly inverted) value,
// cin_o: +1 that completes the two's-complement negation in the accumulator add.
module booth_pp_row import booth_pkg::*; #(parameter int W = 8) (
    input  logic [W+1:0] a_i,
    input  booth_sel_t   sel_i,
    output logic [W+1:0] pp_o,
    output logic         cin_o
);
    logic [W+1:0] mag;
    always_comb begin
        mag   = sel_i.s ? a_i : sel_i.d ? {a_i[W:0], 1'b0} : '0;
        pp_o  = sel_i.n ? ~mag : mag;
        cin_o = sel_i.n;
    end
endmodule

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: iterative radix-4 Booth multiplier, one partial product per clock
// clk, reset (sync, active-high); bus: booth_seq_mult_if slave (operands in, 2W-bit product out).
// Define BOOTH_UNSIGNED_EN to add is_unsigned and run W/2+1 iterations for every operation.
module booth_seq_mult import booth_pkg::*; #(parameter int W = 8) (
    input logic             clk,
    input logic             reset,
    booth_seq_mult_if.slave bus
);
`ifdef BOOTH_UNSIGNED_EN
    localparam int K = W / 2 + 1;
`else
    localparam int K = W / 2;
`endif
    localparam int AW = 2 * W + 4;
    localparam int CW = $clog2(K) + 1;
    state_t         state_q;
    logic [W+1:0]   a_q;
    logic [2*K:0]   m_q;
    logic [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q;
    logic           in_ready_q, out_valid_q;
    logic [2*W-1:0] product_q;
    logic [W+1:0]   pp;
    logic           cin;
    logic [CW:0]    sh;
    logic           fill_a, fill_b;
    logic [2*K-1:0] b_ext;
    booth_sel_t     sel;
`ifdef BOOTH_UNSIGNED_EN
    assign fill_a = !bus.is_unsigned && bus.a[W-1];
    assign fill_b = !bus.is_unsigned && bus.b[W-1];
    assign b_ext  = {{2{fill_b}}, bus.b};
`else
    assign fill_a = bus.a[W-1];
    assign fill_b = bus.b[W-1];
    assign b_ext  = bus.b;
`endif
    assign sel = booth_encode(m_q[2:0]);
    booth_pp_row #(.W(W)) u_row (
        .a_i   (a_q),
        .sel_i (sel),
        .pp_o  (pp),
        .cin_o (cin)
    );
    // Row i carries weight 4^i; the negation carry-in enters at the same weight
    always_comb begin
        sh    = {cnt_q, 1'b0};
        acc_d = acc_q + ({{(W + 2){pp[W+1]}}, pp} << sh) + ({{(AW - 1){1'b0}}, cin} << sh);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            m_q         <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    a_q        <= {{2{fill_a}}, bus.a};
                    m_q        <= {b_ext, 1'b0};
                    acc_q      <= '0;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b0;
                    state_q    <= RUN;
                end
                RUN: begin
                    acc_q <= acc_d;
                    m_q   <= {{2{m_q[2*K]}}, m_q[2*K:2]};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(K - 1)) begin
                        product_q   <= acc_d[2*W-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: directed and sweep checks of booth_seq_mult at W=8 and W=16 against a cycle-level model
module tb_booth_seq_mult;
`ifdef BOOTH_UNSIGNED_EN
    localparam int K8 = 5;
    localparam int K16 = 9;
`else
    localparam int K8 = 4;
    localparam int K16 = 8;
`endif
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst8, rst16;
    int passed = 0;
    int total = 0;
    booth_seq_mult_if #(.W(8))  if8();
    booth_seq_mult_if #(.W(16)) if16();
    booth_seq_mult #(.W(8))  dut8  (.clk(clk), .reset(rst8),  .bus(if8));
    booth_seq_mult #(.W(16)) dut16 (.clk(clk), .reset(rst16), .bus(if16));
    logic   rst[2], iv[2], ir[2], ov[2], ordy[2], us[2];
    longint va[2], vb[2], ua[2], ub[2], pr[2];
    int     kk[2] = '{K8, K16};
    longint msk[2] = '{64'hFFFF, 64'hFFFF_FFFF};
    assign rst[0] = rst8;               assign rst[1] = rst16;
    assign iv[0] = if8.in_valid;        assign iv[1] = if16.in_valid;
    assign ir[0] = if8.in_ready;        assign ir[1] = if16.in_ready;
    assign ov[0] = if8.out_valid;       assign ov[1] = if16.out_valid;
    assign ordy[0] = if8.out_ready;     assign ordy[1] = if16.out_ready;
    assign va[0] = longint'($signed(if8.a));  assign va[1] = longint'($signed(if16.a));
    assign vb[0] = longint'($signed(if8.b));  assign vb[1] = longint'($signed(if16.b));
    assign ua[0] = longint'(if8.a);     assign ua[1] = longint'(if16.a);
    assign ub[0] = longint'(if8.b);     assign ub[1] = longint'(if16.b);
    assign pr[0] = longint'(if8.product); assign pr[1] = longint'(if16.product);
`ifdef BOOTH_UNSIGNED_EN
    assign us[0] = if8.is_unsigned;     assign us[1] = if16.is_unsigned;
`else
    assign us[0] = 1'b0;                assign us[1] = 1'b0;
`endif
    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask
    // Model: cycles since acceptance; result shows K+1 cycles after the accept cycle, held until taken
    logic   m_busy[2];
    int     m_cnt[2];
    longint m_exp[2], m_prod[2];
    logic   started = 1'b0;
    always @(posedge clk) begin
        if (rst8 && rst16) started <= 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                m_busy[d] <= 1'b0;
                m_cnt[d]  <= 0;
                m_prod[d] <= 0;
            end else if (!m_busy[d]) begin
                if (iv[d]) begin
                    m_busy[d] <= 1'b1;
                    m_cnt[d]  <= 1;
                    m_exp[d]  <= (us[d] ? ua[d] * ub[d] : va[d] * vb[d]) & msk[d];
                end
            end else if (m_cnt[d] <= kk[d]) begin
                m_cnt[d] <= m_cnt[d] + 1;
                if (m_cnt[d] == kk[d]) m_prod[d] <= m_exp[d];
            end else if (ordy[d]) begin
                m_busy[d] <= 1'b0;
            end
        end
    end
    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                check(d == 0 ? "w8 in_ready" : "w16 in_ready", longint'(ir[d]), longint'(!m_busy[d]));
                check(d == 0 ? "w8 out_valid" : "w16 out_valid", longint'(ov[d]),
                      longint'(m_busy[d] && m_cnt[d] == kk[d] + 1));
                check(d == 0 ? "w8 product" : "w16 product", pr[d], m_prod[d]);
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_ov(input int d, output int n);
        n = 0;
        while (!ov[d] && n < 50) begin
            tick();
            n++;
        end
    endtask
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input longint exp, input string nm);
        int n;
        if8.a = a;
        if8.b = b;
        if8.out_ready = 1'b1;
        if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        wait_ov(0, n);
        check({nm, " latency"}, longint'(n), longint'(K8));
        check({nm, " product"}, longint'(if8.product), exp);
        tick();
        check({nm, " in_ready after handshake"}, longint'(if8.in_ready), 1);
    endtask
    task automatic run16(input logic [15:0] a, input logic [15:0] b);
        int n;
        longint exp;
        exp = (longint'($signed(a)) * longint'($signed(b))) & 64'hFFFF_FFFF;
        if16.a = a;
        if16.b = b;
        if16.out_ready = 1'b1;
        if16.in_valid = 1'b1;
        tick();
        if16.in_valid = 1'b0;
        wait_ov(1, n);
        check("w16 sweep latency", longint'(n), longint'(K16));
        check("w16 sweep product", longint'(if16.product), exp);
        tick();
    endtask
    initial begin
        int n;
        logic [15:0] ca[6] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h8000};
        logic [15:0] cb[6] = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001};
        rst8 = 1'b1;
        rst16 = 1'b1;
        if8.in_valid = 1'b0;  if8.a = '0;  if8.b = '0;  if8.out_ready = 1'b0;
        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.out_ready = 1'b0;
`ifdef BOOTH_UNSIGNED_EN
        if8.is_unsigned = 1'b0;
        if16.is_unsigned = 1'b0;
`endif
        repeat (2) tick();
        rst8 = 1'b0;
        rst16 = 1'b0;
        check("reset in_ready", longint'(if8.in_ready), 1);
        check("reset out_valid", longint'(if8.out_valid), 0);
        check("reset product", longint'(if8.product), 0);
        run8(8'd7, 8'hFD, 64'hFFEB, "7x-3");
        run8(8'h80, 8'h80, 64'h4000, "-128x-128");
        run8(8'h00, 8'h80, 64'h0000, "0x-128");
        // Product held while the consumer stalls; a competing request must be ignored
        if8.a = 8'd5;
        if8.b = 8'd9;
        if8.out_ready = 1'b0;
        if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        wait_ov(0, n);
        check("5x9 latency", longint'(n), longint'(K8));
        check("5x9 product", longint'(if8.product), 64'h002D);
        if8.a = 8'd1;
        if8.b = 8'd1;
        if8.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stall product", longint'(if8.product), 64'h002D);
            check("stall in_ready", longint'(if8.in_ready), 0);
            check("stall out_valid", longint'(if8.out_valid), 1);
        end
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b1;
        tick();
        check("stall release in_ready", longint'(if8.in_ready), 1);
        check("stall release out_valid", longint'(if8.out_valid), 0);
        // Abort in the second RUN cycle
        if8.a = 8'd7;
        if8.b = 8'hFD;
        if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        tick();
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        check("abort in_ready", longint'(if8.in_ready), 1);
        check("abort out_valid", longint'(if8.out_valid), 0);
        check("abort product", longint'(if8.product), 0);
        repeat (6) tick();
        check("abort no late out_valid", longint'(if8.out_valid), 0);
        run8(8'd3, 8'd3, 64'h0009, "3x3");
`ifdef BOOTH_UNSIGNED_EN
        if8.is_unsigned = 1'b1;
        run8(8'hFF, 8'hFF, 64'hFE01, "u255x255");
        if8.is_unsigned = 1'b0;
        run8(8'hFF, 8'hFF, 64'h0001, "s-1x-1");
`endif
        for (int i = 0; i < 6; i++) run16(ca[i], cb[i]);
        for (int i = 0; i < 1000; i++) run16(16'($urandom), 16'($urandom));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
